// File: rtl/issue_unit.sv
// Issue/execute stage: picks one ready queue head per cycle (div > mult > int),
// runs it on a fixed-latency unit and books its exact CDB slot at issue time.
module issue_unit #(
  parameter int unsigned MULT_LAT = 4,
  parameter int unsigned DIV_LAT  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  equeueint_opcode,
  input  logic [5:0]  equeueint_rdtag,
  input  logic [31:0] equeueint_rsdata,
  input  logic [31:0] equeueint_rtdata,
  input  logic        equeueint_ready,
  output logic        equeueint_done,
  input  logic [5:0]  equeuemult_rdtag,
  input  logic [31:0] equeuemult_rsdata,
  input  logic [31:0] equeuemult_rtdata,
  input  logic        equeuemult_ready,
  output logic        equeuemult_done,
  input  logic [5:0]  equeuediv_rdtag,
  input  logic [31:0] equeuediv_rsdata,
  input  logic [31:0] equeuediv_rtdata,
  input  logic        equeuediv_ready,
  output logic        equeuediv_done,
  output logic [31:0] cdb_data,
  output logic [5:0]  cdb_tag,
  output logic        cdb_valid,
  output logic        cdb_branch,
  output logic        cdb_taken
);

  localparam int unsigned DW        = 32;
  localparam int unsigned TW        = 6;
  localparam int unsigned DIV_STEPS = DIV_LAT - 1;
  localparam int unsigned DIV_BPC   = (DW + DIV_STEPS - 1) / DIV_STEPS;
  localparam int unsigned CW        = $clog2(DIV_LAT);
  localparam int unsigned BW        = $clog2(DW + 1);

  typedef struct packed {
    logic          valid;
    logic          branch;
    logic          taken;
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
  } cdb_t;

  typedef enum logic [0:0] {DIV_IDLE, DIV_RUN} div_state_t;

  logic [DIV_LAT:1] res, res_nxt;
  logic             issue_int, issue_mult, issue_div;
  logic             div_busy;
  cdb_t             cdb_q, cdb_nxt;

  // ALU result for the integer head
  logic [DW-1:0] alu_data;
  logic          alu_branch, alu_taken;

  // Multiplier pipeline; stage MULT_LAT-1 feeds the CDB register
  cdb_t mul_pipe [1:MULT_LAT-1];

  // Iterative restoring divider
  div_state_t    div_state, div_state_nxt;
  logic [CW-1:0] div_cnt;
  logic [BW-1:0] div_left, left_v;
  logic [DW-1:0] div_dvd, div_dsr, div_rem, div_quo;
  logic [DW-1:0] dvd_v, rem_v, quo_v;
  logic [DW:0]   trial;
  logic [TW-1:0] div_tag;
  logic          div_fin;

  assign div_busy = (div_state == DIV_RUN);

  // Issue selection: longest latency first, one issue per cycle
  always_comb begin
    issue_div  = reset && equeuediv_ready && !res[DIV_LAT] && !div_busy;
    issue_mult = reset && equeuemult_ready && !res[MULT_LAT] && !issue_div;
    issue_int  = reset && equeueint_ready && !res[1] && !issue_div && !issue_mult;
  end

  assign equeueint_done  = issue_int;
  assign equeuemult_done = issue_mult;
  assign equeuediv_done  = issue_div;

  // Reservation shifts toward "now"; a new op claims its slot as seen next cycle
  always_comb begin
    res_nxt = '0;
    for (int unsigned k = 1; k < DIV_LAT; k++) res_nxt[k] = res[k+1];
    if (issue_mult) res_nxt[MULT_LAT-1] = 1'b1;
    if (issue_div)  res_nxt[DIV_LAT-1]  = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) res <= '0;
    else        res <= res_nxt;
  end

  always_comb begin
    alu_data   = '0;
    alu_branch = 1'b0;
    alu_taken  = 1'b0;
    case (equeueint_opcode)
      4'd0: alu_data = equeueint_rsdata + equeueint_rtdata;
      4'd1: alu_data = equeueint_rsdata - equeueint_rtdata;
      4'd2: alu_data = equeueint_rsdata & equeueint_rtdata;
      4'd3: alu_data = equeueint_rsdata | equeueint_rtdata;
      4'd4: alu_data = equeueint_rsdata ^ equeueint_rtdata;
      4'd5: alu_data = ~(equeueint_rsdata | equeueint_rtdata);
      4'd6: alu_data = {{(DW-1){1'b0}}, $signed(equeueint_rsdata) < $signed(equeueint_rtdata)};
      4'd7: alu_data = {{(DW-1){1'b0}}, equeueint_rsdata < equeueint_rtdata};
      4'd8: begin
        alu_branch = 1'b1;
        alu_taken  = (equeueint_rsdata == equeueint_rtdata);
      end
      4'd9: begin
        alu_branch = 1'b1;
        alu_taken  = (equeueint_rsdata != equeueint_rtdata);
      end
      default: alu_data = '0;
    endcase
  end

  // Low 32 bits of a product are identical for signed and unsigned operands
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned k = 1; k < MULT_LAT; k++) mul_pipe[k] <= '0;
    end else begin
      mul_pipe[1] <= issue_mult ?
        cdb_t'({1'b1, 1'b0, 1'b0, equeuemult_rdtag, DW'(equeuemult_rsdata * equeuemult_rtdata)}) :
        '0;
      for (int unsigned k = 2; k < MULT_LAT; k++) mul_pipe[k] <= mul_pipe[k-1];
    end
  end

  // Divider control
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) div_state <= DIV_IDLE;
    else        div_state <= div_state_nxt;
  end

  always_comb begin
    div_state_nxt = div_state;
    div_fin       = 1'b0;
    case (div_state)
      DIV_IDLE: if (issue_div) div_state_nxt = DIV_RUN;
      DIV_RUN: begin
        if (div_cnt == CW'(1)) begin
          div_state_nxt = DIV_IDLE;
          div_fin       = 1'b1;
        end
      end
      default: div_state_nxt = DIV_IDLE;
    endcase
  end

  // DIV_BPC quotient bits per cycle; a zero divisor yields all-ones naturally
  always_comb begin
    rem_v  = div_rem;
    dvd_v  = div_dvd;
    quo_v  = div_quo;
    left_v = div_left;
    trial  = '0;
    for (int unsigned i = 0; i < DIV_BPC; i++) begin
      if (left_v != '0) begin
        trial = {rem_v, dvd_v[DW-1]};
        dvd_v = {dvd_v[DW-2:0], 1'b0};
        if (trial >= {1'b0, div_dsr}) begin
          rem_v = DW'(trial - {1'b0, div_dsr});
          quo_v = {quo_v[DW-2:0], 1'b1};
        end else begin
          rem_v = trial[DW-1:0];
          quo_v = {quo_v[DW-2:0], 1'b0};
        end
        left_v = left_v - BW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt  <= '0;
      div_left <= '0;
      div_dvd  <= '0;
      div_dsr  <= '0;
      div_rem  <= '0;
      div_quo  <= '0;
      div_tag  <= '0;
    end else if (issue_div) begin
      div_cnt  <= CW'(DIV_LAT - 1);
      div_left <= BW'(DW);
      div_dvd  <= equeuediv_rsdata;
      div_dsr  <= equeuediv_rtdata;
      div_rem  <= '0;
      div_quo  <= '0;
      div_tag  <= equeuediv_rdtag;
    end else if (div_busy) begin
      div_cnt  <= div_cnt - CW'(1);
      div_left <= left_v;
      div_dvd  <= dvd_v;
      div_rem  <= rem_v;
      div_quo  <= quo_v;
    end
  end

  // Reservation guarantees at most one source is active here
  always_comb begin
    cdb_nxt = '0;
    if (issue_int)
      cdb_nxt = {1'b1, alu_branch, alu_taken, equeueint_rdtag, alu_data};
    else if (mul_pipe[MULT_LAT-1].valid)
      cdb_nxt = mul_pipe[MULT_LAT-1];
    else if (div_fin)
      cdb_nxt = {1'b1, 1'b0, 1'b0, div_tag, quo_v};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cdb_q <= '0;
    else        cdb_q <= cdb_nxt;
  end

  assign cdb_valid  = cdb_q.valid;
  assign cdb_branch = cdb_q.branch;
  assign cdb_taken  = cdb_q.taken;
  assign cdb_tag    = cdb_q.tag;
  assign cdb_data   = cdb_q.data;

endmodule

// File: tb/tb_issue_unit.sv
// Scoreboard bench for issue_unit: predicts issue choice and the exact CDB
// cycle/payload of every op from queue contents alone.
module tb_issue_unit;

  localparam int MULT_LAT = 4;
  localparam int DIV_LAT  = 8;
  localparam int RST_CYC  = 62;
  localparam int END_CYC  = 200;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  equeueint_opcode;
  logic [5:0]  equeueint_rdtag, equeuemult_rdtag, equeuediv_rdtag;
  logic [31:0] equeueint_rsdata, equeueint_rtdata;
  logic [31:0] equeuemult_rsdata, equeuemult_rtdata;
  logic [31:0] equeuediv_rsdata, equeuediv_rtdata;
  logic        equeueint_ready, equeuemult_ready, equeuediv_ready;
  logic        equeueint_done, equeuemult_done, equeuediv_done;
  logic [31:0] cdb_data;
  logic [5:0]  cdb_tag;
  logic        cdb_valid, cdb_branch, cdb_taken;

  always #5 clk = ~clk;

  issue_unit #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .reset(reset),
    .equeueint_opcode(equeueint_opcode), .equeueint_rdtag(equeueint_rdtag),
    .equeueint_rsdata(equeueint_rsdata), .equeueint_rtdata(equeueint_rtdata),
    .equeueint_ready(equeueint_ready), .equeueint_done(equeueint_done),
    .equeuemult_rdtag(equeuemult_rdtag), .equeuemult_rsdata(equeuemult_rsdata),
    .equeuemult_rtdata(equeuemult_rtdata), .equeuemult_ready(equeuemult_ready),
    .equeuemult_done(equeuemult_done),
    .equeuediv_rdtag(equeuediv_rdtag), .equeuediv_rsdata(equeuediv_rsdata),
    .equeuediv_rtdata(equeuediv_rtdata), .equeuediv_ready(equeuediv_ready),
    .equeuediv_done(equeuediv_done),
    .cdb_data(cdb_data), .cdb_tag(cdb_tag), .cdb_valid(cdb_valid),
    .cdb_branch(cdb_branch), .cdb_taken(cdb_taken)
  );

  typedef struct {
    int          start;
    logic [3:0]  opc;
    logic [5:0]  tag;
    logic [31:0] rs;
    logic [31:0] rt;
  } op_t;

  typedef struct {
    int          due;
    logic [5:0]  tag;
    logic [31:0] data;
    logic        br;
    logic        tk;
    logic        is_div;
  } exp_t;

  op_t  iq[$], mq[$], dq[$];
  exp_t sb[$];
  int   cyc, total, bad;
  bit   iss_i, iss_m, iss_d;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  // {branch, taken, data}
  function automatic logic [33:0] alu_ref(input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = 32'd0;
    case (opc)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~(a | b);
      4'd6: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd7: r = (a < b) ? 32'd1 : 32'd0;
      4'd8: return {1'b1, a == b, 32'd0};
      4'd9: return {1'b1, a != b, 32'd0};
      default: r = 32'd0;
    endcase
    return {2'b00, r};
  endfunction

  function automatic logic [31:0] mul_ref(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb_, p;
    sa  = 64'($signed(a));
    sb_ = 64'($signed(b));
    p   = sa * sb_;
    return p[31:0];
  endfunction

  function automatic logic [31:0] div_ref(input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
  endfunction

  task automatic add_op(input int q, input int s, input int opc, input int tag,
                        input logic [31:0] a, input logic [31:0] b);
    op_t o;
    o = '{s, 4'(opc), 6'(tag), a, b};
    if (q == 0) iq.push_back(o);
    else if (q == 1) mq.push_back(o);
    else dq.push_back(o);
  endtask

  task automatic drive();
    equeueint_ready  = (iq.size() != 0) && (iq[0].start <= cyc);
    equeuemult_ready = (mq.size() != 0) && (mq[0].start <= cyc);
    equeuediv_ready  = (dq.size() != 0) && (dq[0].start <= cyc);
    if (iq.size() != 0) begin
      equeueint_opcode = iq[0].opc; equeueint_rdtag = iq[0].tag;
      equeueint_rsdata = iq[0].rs;  equeueint_rtdata = iq[0].rt;
    end
    if (mq.size() != 0) begin
      equeuemult_rdtag = mq[0].tag; equeuemult_rsdata = mq[0].rs; equeuemult_rtdata = mq[0].rt;
    end
    if (dq.size() != 0) begin
      equeuediv_rdtag = dq[0].tag; equeuediv_rsdata = dq[0].rs; equeuediv_rtdata = dq[0].rt;
    end
  endtask

  // Compare CDB against due entry, then predict this cycle's issue and book results
  task automatic monitor();
    int hit;
    bit r1, rm, rd, busy;
    logic [33:0] a;
    hit = -1; r1 = 0; rm = 0; rd = 0; busy = 0;
    foreach (sb[k]) if (sb[k].due == cyc) hit = k;
    if (hit >= 0) begin
      check("cdb", 64'({cdb_valid, cdb_branch, cdb_taken, cdb_tag, cdb_data}),
            64'({1'b1, sb[hit].br, sb[hit].tk, sb[hit].tag, sb[hit].data}));
      sb.delete(hit);
    end else begin
      check("cdb_idle", 64'({cdb_valid, cdb_branch, cdb_taken, cdb_tag, cdb_data}), 64'(0));
    end
    foreach (sb[k]) begin
      if (sb[k].due == cyc + 1)        r1 = 1;
      if (sb[k].due == cyc + MULT_LAT) rm = 1;
      if (sb[k].due == cyc + DIV_LAT)  rd = 1;
      if (sb[k].is_div)                busy = 1;
    end
    iss_d = reset && equeuediv_ready && !rd && !busy;
    iss_m = reset && equeuemult_ready && !rm && !iss_d;
    iss_i = reset && equeueint_ready && !r1 && !iss_d && !iss_m;
    check("done", 64'({equeuediv_done, equeuemult_done, equeueint_done}),
          64'({iss_d, iss_m, iss_i}));
    if (iss_i) begin
      a = alu_ref(iq[0].opc, iq[0].rs, iq[0].rt);
      sb.push_back('{cyc + 1, iq[0].tag, a[31:0], a[33], a[32], 1'b0});
    end
    if (iss_m)
      sb.push_back('{cyc + MULT_LAT, mq[0].tag, mul_ref(mq[0].rs, mq[0].rt), 1'b0, 1'b0, 1'b0});
    if (iss_d)
      sb.push_back('{cyc + DIV_LAT, dq[0].tag, div_ref(dq[0].rs, dq[0].rt), 1'b0, 1'b0, 1'b1});
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0;
    iss_i = 0; iss_m = 0; iss_d = 0;
    reset = 1'b0;
    equeueint_opcode = '0; equeueint_rdtag = '0; equeueint_rsdata = '0; equeueint_rtdata = '0;
    equeuemult_rdtag = '0; equeuemult_rsdata = '0; equeuemult_rtdata = '0;
    equeuediv_rdtag = '0; equeuediv_rsdata = '0; equeuediv_rtdata = '0;
    equeueint_ready = 0; equeuemult_ready = 0; equeuediv_ready = 0;

    // Basic ALU and branches
    add_op(0, 0, 0, 3, 32'd5, 32'd7);
    add_op(0, 1, 8, 4, 32'd9, 32'd9);
    add_op(0, 2, 9, 5, 32'd9, 32'd9);
    // Mult vs. continuously ready int
    add_op(1, 10, 0, 10, 32'hFFFF_FFFD, 32'd4);
    add_op(0, 10, 1, 6, 32'd3, 32'd10);
    add_op(0, 10, 2, 7, 32'hF0F0_1234, 32'h0FF0_FF00);
    add_op(0, 10, 3, 8, 32'hF000_0000, 32'h0000_000F);
    add_op(0, 10, 4, 9, 32'hAAAA_5555, 32'hFFFF_0000);
    add_op(0, 10, 5, 11, 32'h1234_0000, 32'h0000_5678);
    add_op(0, 10, 6, 12, 32'hFFFF_FFFF, 32'd1);
    add_op(0, 10, 7, 13, 32'hFFFF_FFFF, 32'd1);
    add_op(0, 10, 12, 14, 32'd77, 32'd88);
    // Divider back-to-back, slot conflict with mult
    add_op(2, 30, 0, 20, 32'd100, 32'd7);
    add_op(2, 30, 0, 21, 32'd5, 32'd0);
    add_op(0, 32, 0, 23, 32'd1, 32'd2);
    add_op(1, 34, 0, 22, 32'd2000, 32'hFFFF_FFFD);
    add_op(1, 35, 0, 24, 32'h0001_0000, 32'h0001_0000);
    // In-flight ops killed by reset, then fresh work
    add_op(1, 59, 0, 30, 32'd11, 32'd13);
    add_op(2, 60, 0, 31, 32'd99, 32'd3);
    add_op(0, 61, 4, 29, 32'hDEAD_BEEF, 32'h1234_5678);
    add_op(0, 62, 0, 32, 32'd7, 32'd8);
    add_op(1, 62, 0, 33, 32'd6, 32'd7);
    // Random tail
    for (int i = 0; i < 10; i++)
      add_op(0, 80 + 4 * i, int'($urandom_range(0, 15)), 40 + i, $urandom, $urandom);
    for (int i = 0; i < 6; i++)
      add_op(1, 80 + 5 * i, 0, 50 + i, $urandom, $urandom);
    for (int i = 0; i < 3; i++)
      add_op(2, 82 + 3 * i, 0, 56 + i, $urandom, 32'($urandom_range(0, 50)));

    repeat (3) @(posedge clk);
    #1;
    check("rst_cdb", 64'({cdb_valid, cdb_branch, cdb_taken, cdb_tag, cdb_data}), 64'(0));
    reset = 1'b1;
    cyc = 0;
    while (cyc < END_CYC) begin
      if (cyc == RST_CYC + 1) reset = 1'b1;
      drive();
      if (cyc == RST_CYC) begin
        #1 reset = 1'b0;
        #1;
        check("rst_now_cdb", 64'({cdb_valid, cdb_branch, cdb_taken, cdb_tag, cdb_data}), 64'(0));
        check("rst_now_done", 64'({equeuediv_done, equeuemult_done, equeueint_done}), 64'(0));
        sb.delete();
      end
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
      if (iss_i) void'(iq.pop_front());
      if (iss_m) void'(mq.pop_front());
      if (iss_d) void'(dq.pop_front());
      cyc++;
    end
    check("sb_empty", 64'(sb.size()), 64'(0));
    check("drained", 64'(iq.size() + mq.size() + dq.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
